// File: rtl/extended_hamming_stream_encoder.sv
// Extended Hamming (SECDED) stream encoder with optional error injection.
// Each accepted payload beat is encoded into one block. The block can be
// deliberately corrupted with a single or double bit flip, then queued in a
// two-entry skid buffer that drives the registered read-side handshake.
//
// Block layout: bit 0 holds overall (even) parity over the whole block.
// Bits 1..BLOCK_WIDTH-1 are a classic Hamming code word: positions that are
// powers of two carry check bits, and the remaining positions carry payload
// bits in ascending order (LSB of write_data at the lowest data position).
module extended_hamming_stream_encoder #(
    parameter int DATA_WIDTH = 4,
    localparam int HAMMING_BITS = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1),
    localparam int PARITY_WIDTH = HAMMING_BITS + 1,
    localparam int BLOCK_WIDTH = DATA_WIDTH + PARITY_WIDTH,
    localparam int POS_WIDTH = $clog2(BLOCK_WIDTH)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   write_valid,
    output logic                   write_ready,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   inject_single,
    input  logic                   inject_double,
    input  logic [POS_WIDTH-1:0]   inject_position,
    output logic                   read_valid,
    input  logic                   read_ready,
    output logic [BLOCK_WIDTH-1:0] read_block,
    output logic [1:0]             read_injected,
    output logic [15:0]            injection_count
);

    typedef enum logic [1:0] {
        STATE_EMPTY = 2'd0,
        STATE_ONE   = 2'd1,
        STATE_FULL  = 2'd2
    } bufferState_t;

    bufferState_t           state_q, state_d;
    logic [BLOCK_WIDTH-1:0] mainBlock_q, mainBlock_d;
    logic [1:0]             mainTag_q, mainTag_d;
    logic [BLOCK_WIDTH-1:0] skidBlock_q, skidBlock_d;
    logic [1:0]             skidTag_q, skidTag_d;
    logic                   readValid_q, readValid_d;
    logic                   writeReady_q, writeReady_d;
    logic [15:0]            count_q, count_d;

    logic [BLOCK_WIDTH-1:0] codeWord;
    logic [BLOCK_WIDTH-1:0] flipMask;
    logic [BLOCK_WIDTH-1:0] newBlock;
    logic [1:0]             newTag;
    logic                   checkBit;
    int                     dataIdx;
    int                     posFirst;
    int                     posSecond;
    logic                   accept;
    logic                   transfer;

    // Build the clean SECDED block for the incoming payload.
    always_comb begin
        codeWord = '0;
        dataIdx  = 0;
        checkBit = 1'b0;
        for (int pos = 1; pos < BLOCK_WIDTH; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                codeWord[pos] = write_data[dataIdx];
                dataIdx       = dataIdx + 1;
            end
        end
        for (int b = 0; b < HAMMING_BITS; b++) begin
            checkBit = 1'b0;
            for (int pos = 1; pos < BLOCK_WIDTH; pos++) begin
                if (((pos >> b) & 1) == 1) begin
                    checkBit = checkBit ^ codeWord[pos];
                end
            end
            codeWord[1 << b] = checkBit;
        end
        codeWord[0] = ^codeWord[BLOCK_WIDTH-1:1];
    end

    // Apply the requested corruption; double injection wins over single.
    always_comb begin
        posFirst  = int'(inject_position) % BLOCK_WIDTH;
        posSecond = (posFirst == BLOCK_WIDTH - 1) ? 0 : posFirst + 1;
        flipMask  = '0;
        newTag    = 2'b00;
        for (int i = 0; i < BLOCK_WIDTH; i++) begin
            flipMask[i] = ((inject_single || inject_double) && (i == posFirst)) ||
                          (inject_double && (i == posSecond));
        end
        if (inject_double) begin
            newTag = 2'b10;
        end else if (inject_single) begin
            newTag = 2'b01;
        end
        newBlock = codeWord ^ flipMask;
    end

    assign accept   = write_valid && writeReady_q;
    assign transfer = readValid_q && read_ready;

    // Skid buffer next-state logic, handshake flags and injection counter.
    always_comb begin
        state_d     = state_q;
        mainBlock_d = mainBlock_q;
        mainTag_d   = mainTag_q;
        skidBlock_d = skidBlock_q;
        skidTag_d   = skidTag_q;
        count_d     = count_q;

        if (transfer && (mainTag_q != 2'b00) && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end

        case (state_q)
            STATE_EMPTY: begin
                if (accept) begin
                    mainBlock_d = newBlock;
                    mainTag_d   = newTag;
                    state_d     = STATE_ONE;
                end
            end
            STATE_ONE: begin
                if (accept && transfer) begin
                    mainBlock_d = newBlock;
                    mainTag_d   = newTag;
                end else if (accept) begin
                    skidBlock_d = newBlock;
                    skidTag_d   = newTag;
                    state_d     = STATE_FULL;
                end else if (transfer) begin
                    state_d = STATE_EMPTY;
                end
            end
            STATE_FULL: begin
                if (transfer) begin
                    mainBlock_d = skidBlock_q;
                    mainTag_d   = skidTag_q;
                    state_d     = STATE_ONE;
                end
            end
            default: begin
                state_d = STATE_EMPTY;
            end
        endcase

        readValid_d  = (state_d != STATE_EMPTY);
        writeReady_d = (state_d != STATE_FULL);
    end

    // State and output registers, cleared asynchronously by resetn.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= STATE_EMPTY;
            mainBlock_q  <= '0;
            mainTag_q    <= 2'b00;
            skidBlock_q  <= '0;
            skidTag_q    <= 2'b00;
            readValid_q  <= 1'b0;
            writeReady_q <= 1'b0;
            count_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            mainBlock_q  <= mainBlock_d;
            mainTag_q    <= mainTag_d;
            skidBlock_q  <= skidBlock_d;
            skidTag_q    <= skidTag_d;
            readValid_q  <= readValid_d;
            writeReady_q <= writeReady_d;
            count_q      <= count_d;
        end
    end

    assign write_ready     = writeReady_q;
    assign read_valid      = readValid_q;
    assign read_block      = mainBlock_q;
    assign read_injected   = mainTag_q;
    assign injection_count = count_q;

endmodule

// File: tb/tb_extended_hamming_stream_encoder.sv
// Scoreboard testbench for extended_hamming_stream_encoder (DATA_WIDTH=4).
// The driver pushes the expected block for every accepted beat; an
// independent monitor pops and compares whenever a block is transferred out.
module tb_extended_hamming_stream_encoder;

    localparam int DW = 4;
    localparam int BW = 8;

    logic          clock = 1'b0;
    logic          resetn;
    logic          write_valid;
    logic          write_ready;
    logic [DW-1:0] write_data;
    logic          inject_single;
    logic          inject_double;
    logic [2:0]    inject_position;
    logic          read_valid;
    logic          read_ready;
    logic [BW-1:0] read_block;
    logic [1:0]    read_injected;
    logic [15:0]   injection_count;

    typedef struct packed {
        logic [BW-1:0] blk;
        logic [1:0]    tag;
    } expBeat_t;

    expBeat_t expQ[$];
    int       checks = 0;
    int       errors = 0;
    int       expCount = 0;
    int       transferCount = 0;
    logic     holdActive = 1'b0;
    logic [BW-1:0] holdBlock = '0;
    logic [1:0]    holdTag = 2'b00;

    always #5 clock = ~clock;

    extended_hamming_stream_encoder #(.DATA_WIDTH(DW)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .write_valid     (write_valid),
        .write_ready     (write_ready),
        .write_data      (write_data),
        .inject_single   (inject_single),
        .inject_double   (inject_double),
        .inject_position (inject_position),
        .read_valid      (read_valid),
        .read_ready      (read_ready),
        .read_block      (read_block),
        .read_injected   (read_injected),
        .injection_count (injection_count)
    );

    // Reference encoder: place data at non-power-of-two positions, then pick
    // check bits so that the XOR of all set-bit positions becomes zero, and
    // finally make the whole block even parity through bit 0.
    function automatic logic [BW-1:0] refEncode(input logic [DW-1:0] d);
        logic [BW-1:0] c;
        int k;
        int syn;
        c = '0;
        k = 0;
        syn = 0;
        for (int pos = 1; pos < BW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int pos = 1; pos < BW; pos++) if (c[pos]) syn ^= pos;
        for (int b = 0; b < 3; b++) if (((syn >> b) & 1) == 1) c[1 << b] = 1'b1;
        c[0] = ^c[BW-1:1];
        return c;
    endfunction

    function automatic expBeat_t refBeat(input logic [DW-1:0] d, input logic s,
                                         input logic dbl, input logic [2:0] p);
        expBeat_t e;
        int first;
        int second;
        first  = int'(p) % BW;
        second = (first + 1) % BW;
        e.blk = refEncode(d);
        e.tag = 2'b00;
        if (dbl) begin
            e.blk[first]  = ~e.blk[first];
            e.blk[second] = ~e.blk[second];
            e.tag = 2'b10;
        end else if (s) begin
            e.blk[first] = ~e.blk[first];
            e.tag = 2'b01;
        end
        return e;
    endfunction

    // Block checker model: 00 clean, 01 correctable, 10 uncorrectable.
    function automatic logic [1:0] classify(input logic [BW-1:0] b);
        int syn;
        syn = 0;
        for (int i = 1; i < BW; i++) if (b[i]) syn ^= i;
        if (^b) return 2'b01;
        if (syn != 0) return 2'b10;
        return 2'b00;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic s,
                                 input logic dbl, input logic [2:0] p, input logic rr,
                                 output logic accepted);
        @(negedge clock);
        write_valid     = v;
        write_data      = d;
        inject_single   = s;
        inject_double   = dbl;
        inject_position = p;
        read_ready      = rr;
        accepted = v && write_ready && resetn;
        if (accepted) expQ.push_back(refBeat(d, s, dbl, p));
    endtask

    task automatic drain(input int budget);
        logic acc;
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b1, acc);
            n++;
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b1, acc);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drainTimeout got %0d pending expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Monitor: sample mid-cycle, check hold stability, the counter, and every
    // transferred block against the scoreboard.
    always @(negedge clock) begin
        #2;
        if (!resetn) begin
            holdActive = 1'b0;
            expCount   = 0;
        end else begin
            if (holdActive) begin
                checkOutput("holdValid", 32'(read_valid), 32'd1);
                checkOutput("holdBlock", 32'(read_block), 32'(holdBlock));
                checkOutput("holdTag", 32'(read_injected), 32'(holdTag));
            end
            checkOutput("injectionCount", 32'(injection_count), 32'(expCount));
            if (read_valid && read_ready) begin
                holdActive = 1'b0;
                transferCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedOutput got block %0h expected none", read_block);
                end else begin
                    expBeat_t e;
                    e = expQ.pop_front();
                    checkOutput("readBlock", 32'(read_block), 32'(e.blk));
                    checkOutput("readInjected", 32'(read_injected), 32'(e.tag));
                    checkOutput("checkerClass", 32'(classify(read_block)), 32'(e.tag));
                    if (e.tag != 2'b00 && expCount < 65535) expCount++;
                end
            end else if (read_valid) begin
                holdActive = 1'b1;
                holdBlock  = read_block;
                holdTag    = read_injected;
            end else begin
                holdActive = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic acc;
        int accCount;
        int startTransfers;

        resetn = 1'b0;
        write_valid = 1'b0;
        write_data = '0;
        inject_single = 1'b0;
        inject_double = 1'b0;
        inject_position = '0;
        read_ready = 1'b0;

        // Reset values.
        repeat (3) @(negedge clock);
        checkOutput("rstReadValid", 32'(read_valid), 32'd0);
        checkOutput("rstWriteReady", 32'(write_ready), 32'd0);
        checkOutput("rstReadBlock", 32'(read_block), 32'd0);
        checkOutput("rstReadInjected", 32'(read_injected), 32'd0);
        checkOutput("rstCount", 32'(injection_count), 32'd0);
        resetn = 1'b1;
        #1 checkOutput("readyBeforeEdge", 32'(write_ready), 32'd0);
        @(posedge clock);
        #1 checkOutput("readyAfterReset", 32'(write_ready), 32'd1);

        // Basic clean beat with one-cycle latency.
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0, 3'd0, 1'b1, acc);
        checkOutput("basicAccept", 32'(acc), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b1, acc);
        checkOutput("basicLatency", 32'(read_valid), 32'd1);
        checkOutput("basicTag", 32'(read_injected), 32'd0);
        drain(10);

        // Single-injection sweep over every bit position.
        for (int i = 0; i < BW; i++) begin
            applyStimulus(1'b1, 4'h5, 1'b1, 1'b0, 3'(i), 1'b1, acc);
            checkOutput("sweepAccept", 32'(acc), 32'd1);
        end
        drain(10);
        checkOutput("sweepCount", 32'(injection_count), 32'd8);

        // Double injection wrapping from bit 7 to bit 0, with single also set.
        applyStimulus(1'b1, 4'h3, 1'b1, 1'b1, 3'd7, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b0, acc);
        checkOutput("wrapBits", 32'(read_block ^ refEncode(4'h3)), 32'h81);
        checkOutput("wrapTag", 32'(read_injected), 32'd2);
        drain(10);
        checkOutput("wrapCount", 32'(injection_count), 32'd9);

        // Backpressure: three write attempts with the reader stalled.
        accCount = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'(i + 1), 1'b0, 1'b0, 3'd0, 1'b0, acc);
            if (acc) accCount++;
        end
        checkOutput("bpAccepted", 32'(accCount), 32'd2);
        checkOutput("bpWriteReady", 32'(write_ready), 32'd0);
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b0, acc);
        drain(10);

        // Streaming at full throughput.
        startTransfers = transferCount;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 4'($urandom), 1'b0, 1'b0, 3'd0, 1'b1, acc);
            checkOutput("streamAccept", 32'(acc), 32'd1);
        end
        drain(3);
        checkOutput("streamTransfers", 32'(transferCount - startTransfers), 32'd100);

        // Random traffic with random injection and backpressure.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 3) == 0), 3'($urandom),
                          1'($urandom_range(0, 3) != 0), acc);
        end
        drain(20);

        // Mid-stream reset while the buffer is full.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'(i + 9), 1'b1, 1'b0, 3'(i), 1'b0, acc);
        end
        checkOutput("fullBeforeReset", 32'(write_ready), 32'd0);
        @(negedge clock);
        #3 resetn = 1'b0;
        expQ.delete();
        #1;
        checkOutput("midRstReadValid", 32'(read_valid), 32'd0);
        checkOutput("midRstWriteReady", 32'(write_ready), 32'd0);
        checkOutput("midRstReadBlock", 32'(read_block), 32'd0);
        checkOutput("midRstReadInjected", 32'(read_injected), 32'd0);
        checkOutput("midRstCount", 32'(injection_count), 32'd0);
        write_valid = 1'b0;
        read_ready = 1'b1;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b1, acc);
            checkOutput("postRstNoOutput", 32'(read_valid), 32'd0);
        end
        applyStimulus(1'b1, 4'hC, 1'b0, 1'b1, 3'd2, 1'b1, acc);
        checkOutput("postRstAccept", 32'(acc), 32'd1);
        drain(10);
        checkOutput("postRstCount", 32'(injection_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/extended_hamming_stream_encoder.md
EXTENDED_HAMMING_STREAM_ENCODER -- requirements
Module: extended_hamming_stream_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, payload bits per block.
REQ-002 SHALL have derived PARITY_WIDTH and BLOCK_WIDTH from the extended_hamming.svh macros (DATA_WIDTH=4 -> PARITY_WIDTH=4, BLOCK_WIDTH=8).
REQ-003 SHALL have port clock  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port write_valid  input  1  upstream data valid.
REQ-006 SHALL have port write_ready  output  1  encoder can accept data.
REQ-007 SHALL have port write_data  input  DATA_WIDTH  payload to encode.
REQ-008 SHALL have port inject_single  input  1  flip one block bit of this beat.
REQ-009 SHALL have port inject_double  input  1  flip two block bits of this beat.
REQ-010 SHALL have port inject_position  input  $clog2(BLOCK_WIDTH)  first flipped bit index.
REQ-011 SHALL have port read_valid  output  1  encoded block valid.
REQ-012 SHALL have port read_ready  input  1  downstream accepts block.
REQ-013 SHALL have port read_block  output  BLOCK_WIDTH  encoded (possibly corrupted) block.
REQ-014 SHALL have port read_injected  output  2  injection tag of read_block: 00 none, 01 single, 10 double.
REQ-015 SHALL have port injection_count  output  16  saturating count of injected blocks transferred out.

Function
REQ-016 SHALL encode with the same block layout as extended_hamming_encoder, so any uncorrupted read_block gives correctable_error=0 and uncorrectable_error=0 at extended_hamming_block_checker.
REQ-017 SHALL accept a beat when write_valid && write_ready, and SHALL transfer out when read_valid && read_ready.
REQ-018 SHALL compute and corrupt the block in the accept cycle and store it in a 2-entry skid buffer (main + skid register); read_block, read_valid and read_injected SHALL be driven from registers.
REQ-019 SHALL have latency of exactly 1 cycle: a beat accepted at edge N appears on read_* after edge N when the buffer was empty.
REQ-020 SHALL register write_ready and assert it only while the skid register is empty, giving full throughput when read_ready stays high.
REQ-021 SHALL have buffer states EMPTY, ONE, FULL with transitions: EMPTY->ONE on accept; ONE->ONE on accept+transfer; ONE->FULL on accept without transfer; ONE->EMPTY on transfer without accept; FULL->ONE on transfer, skid moves to main.
REQ-022 SHALL hold read_block and read_injected stable while read_valid && !read_ready.
REQ-023 SHALL, on single injection, flip bit inject_position mod BLOCK_WIDTH and tag 01.
REQ-024 SHALL, on double injection, flip bits p and (p+1) mod BLOCK_WIDTH, with p = inject_position mod BLOCK_WIDTH, and tag 10.
REQ-025 SHALL give inject_double priority when inject_single and inject_double are both high.
REQ-026 SHALL sample the injection inputs only on accepted beats and ignore them otherwise.
REQ-027 SHALL increment injection_count on each transfer whose tag is non-zero, and saturate at 16'hFFFF.
REQ-028 SHALL leave buffer state unchanged when write_valid is low and read_ready is high with the buffer empty.

Reset
REQ-029 SHALL, while resetn=0, asynchronously force read_valid=0, write_ready=0, read_block=0, read_injected=00, injection_count=0 and buffer state EMPTY.
REQ-030 SHALL raise write_ready on the first rising clock edge after resetn deasserts.
REQ-031 SHALL discard buffered beats on a mid-stream reset, with no partial transfer afterwards.

Verification
REQ-032 SHALL pass a basic scenario: DATA_WIDTH=4, write_data=4'hA, no injection, read_ready=1 -> read_valid one cycle later, checker reports no errors, read_injected=00.
REQ-033 SHALL pass single-injection sweeps: inject_single with inject_position=0..7 on data 4'h5 -> each block has exactly one bit differing from clean, checker correctable_error=1, count rises by 8.
REQ-034 SHALL pass double-injection wrap: inject_double with inject_position=7 -> bits 7 and 0 flipped, checker uncorrectable_error=1, tag 10.
REQ-035 SHALL pass a backpressure scenario: read_ready=0 while writing 3 beats -> accepts 2, write_ready=0 and first block held stable; release gives in-order output with no loss or duplication.
REQ-036 SHALL pass a streaming scenario: write_valid and read_ready high for 100 cycles with random data -> 100 beats out in order, one per cycle, write_ready high throughout.
REQ-037 SHALL pass a reset scenario: resetn low while FULL -> outputs zero immediately; after release no stale block is emitted.
